// File: rtl/hilo_muldiv_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// mult/multu/div/divu latch their operands on acceptance and hold busy for a
// fixed number of cycles; HI/LO are written together on the edge where the
// counter returns to zero. mthi/mtlo write a single register immediately.
module hilo_muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    logic [CntW-1:0] cntQ, cntD;
    logic [2:0]      opQ, opD;
    logic [31:0]     aQ, aD, bQ, bD;
    logic [31:0]     hiQ, hiD, loQ, loD;

    logic        mulSigned, divSigned, isDiv, divByZero;
    logic        divNegA, divNegB;
    logic [63:0] mulA, mulB, product;
    logic [31:0] magA, magB, safeB, uQuot, uRem, quot, rem;
    logic [31:0] resHi, resLo;

    // Result datapath, fed only by the operands latched at acceptance.
    always_comb begin
        mulSigned = (opQ == OpMult);
        divSigned = (opQ == OpDiv);
        isDiv     = (opQ == OpDiv) || (opQ == OpDivu);
        divByZero = isDiv && (bQ == 32'd0);

        // Sign-extend for mult so the low 64 bits of the product are the signed result.
        mulA    = {(mulSigned ? {32{aQ[31]}} : 32'd0), aQ};
        mulB    = {(mulSigned ? {32{bQ[31]}} : 32'd0), bQ};
        product = mulA * mulB;

        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        divNegA = divSigned && aQ[31];
        divNegB = divSigned && bQ[31];
        magA    = divNegA ? (32'd0 - aQ) : aQ;
        magB    = divNegB ? (32'd0 - bQ) : bQ;
        safeB   = (magB == 32'd0) ? 32'd1 : magB;
        uQuot   = magA / safeB;
        uRem    = magA % safeB;
        quot    = (divNegA ^ divNegB) ? (32'd0 - uQuot) : uQuot;
        rem     = divNegA ? (32'd0 - uRem) : uRem;

        resHi = isDiv ? rem  : product[63:32];
        resLo = isDiv ? quot : product[31:0];
    end

    // Next-state: accept when idle, otherwise count down and commit at the last step.
    always_comb begin
        cntD = cntQ;
        opD  = opQ;
        aD   = aQ;
        bD   = bQ;
        hiD  = hiQ;
        loD  = loQ;
        if (start && (cntQ == '0)) begin
            case (op)
                OpMult, OpMultu: begin
                    opD  = op;
                    aD   = a;
                    bD   = b;
                    cntD = MultLoad;
                end
                OpDiv, OpDivu: begin
                    opD  = op;
                    aD   = a;
                    bD   = b;
                    cntD = DivLoad;
                end
                OpMthi:  hiD = a;
                OpMtlo:  loD = a;
                default: ;
            endcase
        end else if (cntQ != '0) begin
            cntD = cntQ - CntOne;
            if ((cntQ == CntOne) && !divByZero) begin
                hiD = resHi;
                loD = resLo;
            end
        end
    end

    // State registers with synchronous reset that also discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cntQ <= '0;
            opQ  <= 3'd0;
            aQ   <= 32'd0;
            bQ   <= 32'd0;
            hiQ  <= 32'd0;
            loQ  <= 32'd0;
        end else begin
            cntQ <= cntD;
            opQ  <= opD;
            aQ   <= aD;
            bQ   <= bD;
            hiQ  <= hiD;
            loQ  <= loD;
        end
    end

    assign busy = (cntQ != '0);
    assign hi   = hiQ;
    assign lo   = loQ;

endmodule
